// File: rtl/seven_seg_result_display.sv
// Result bus to multiplexed 7-segment display.
// Serial double-dabble BCD conversion, blanking, error/overflow glyphs.
module seven_seg_result_display #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           value,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic DP_OFF = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = DIG_ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0][6:0] DIG_RST = (NUM_DIGITS*7)'(7'h3F);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [31:0] last_q, last_d;
  logic [39:0] bcd_q, bcd_d, bcd_adj;
  logic [5:0]  bit_q, bit_d;
  logic        busy_q, busy_d;
  logic [NUM_DIGITS-1:0][6:0] dig_q, dig_d, load_dig;

  logic [CW-1:0] scnt_q, scnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic          dp_q;
  logic          wrap;
  logic          ovf, seen;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0: g = 7'h3F;
      4'd1: g = 7'h06;
      4'd2: g = 7'h5B;
      4'd3: g = 7'h4F;
      4'd4: g = 7'h66;
      4'd5: g = 7'h6D;
      4'd6: g = 7'h7D;
      4'd7: g = 7'h07;
      4'd8: g = 7'h7F;
      4'd9: g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i+:4] >= 4'd5)
        bcd_adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
    end
  end

  // Error beats overflow beats blanked decimal.
  always_comb begin
    ovf  = 1'b0;
    seen = 1'b0;
    load_dig = '0;
    for (int i = 0; i < 10; i++) begin
      if (i >= NUM_DIGITS && bcd_q[4*i+:4] != 4'd0)
        ovf = 1'b1;
    end
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen = seen | (bcd_q[4*i+:4] != 4'd0) | (i == 0);
      load_dig[i] = seen ? glyph(bcd_q[4*i+:4]) : 7'h00;
    end
    if (last_q == 32'hFFFF_FFFF) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        load_dig[i] = (i == 2) ? 7'h79 : (i < 2) ? 7'h50 : 7'h00;
    end else if (ovf) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        load_dig[i] = 7'h40;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    bit_d   = bit_q;
    last_d  = last_q;
    busy_d  = busy_q;
    dig_d   = dig_q;
    unique case (state_q)
      IDLE: begin
        if (value != last_q) begin
          bin_d   = value;
          last_d  = value;
          bcd_d   = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        bit_d = bit_q + 6'd1;
        if (bit_q == 6'd31)
          state_d = LOAD;
      end
      LOAD: begin
        dig_d   = load_dig;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wrap = (scnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    scnt_d = wrap ? '0 : scnt_q + 1'b1;
    idx_d  = idx_q;
    seg_d  = seg_q;
    an_d   = an_q;
    if (wrap) begin
      idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
      seg_d = dig_q[idx_q] ^ {7{SEG_ACTIVE_LOW}};
      an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      bit_q   <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      dig_q   <= DIG_RST;
      scnt_q  <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      dp_q    <= DP_OFF;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      dig_q   <= dig_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= DP_OFF;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = dp_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_seven_seg_result_display.sv
// Bench for seven_seg_result_display, 8 digits, 4-cycle slots.
// Expected display contents are queued at drive time, checked after conversion.
module tb_seven_seg_result_display;

  typedef logic [7:0][6:0] disp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        busy;

  int tests = 0;
  int fails = 0;
  disp_t exp_q[$];

  seven_seg_result_display #(
    .NUM_DIGITS(8), .SCAN_DIV(4),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .value(value),
    .seg(seg), .dp(dp), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] gl(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic disp_t model(input logic [31:0] v);
    disp_t r;
    logic [31:0] t;
    r = '0;
    if (v == 32'hFFFF_FFFF) begin
      r[2] = 7'h79; r[1] = 7'h50; r[0] = 7'h50;
    end else if (v > 32'd99999999) begin
      for (int i = 0; i < 8; i++) r[i] = 7'h40;
    end else begin
      t = v;
      for (int i = 0; i < 8; i++) begin
        if (i == 0 || t != 0) r[i] = gl(int'(t % 10));
        t = t / 10;
      end
    end
    return r;
  endfunction

  function automatic int dec(input logic [7:0] a);
    logic [7:0] m;
    for (int k = 0; k < 8; k++) begin
      m = 8'd1 << k;
      if (a === ~m) return k;
    end
    return -1;
  endfunction

  task automatic drive(input logic [31:0] v);
    value = v;
    exp_q.push_back(model(v));
  endtask

  task automatic pop(output disp_t e);
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard: queue empty, need 1 entry");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic wait_done(output int hi);
    int c = 0;
    hi = 0;
    while (busy !== 1'b1 && c < 20) begin
      @(negedge clk); c++;
    end
    if (busy !== 1'b1) begin
      tests++; fails++;
      $display("FAIL busy_rise: busy=%b after %0d cycles, need 1", busy, c);
      return;
    end
    while (busy === 1'b1 && hi < 100) begin
      hi++; @(negedge clk);
    end
  endtask

  task automatic check_scan(input disp_t e, input string nm);
    logic [7:0] prev;
    logic [7:0] seen = '0;
    int idx, pidx = -1, c = 0;
    prev = an;
    while (an === prev && c < 10) begin
      @(negedge clk); c++;
    end
    for (int c2 = 0; c2 < 32; c2++) begin
      if (c2 == 0 || an !== prev) begin
        prev = an;
        idx = dec(an);
        tests++;
        if (idx < 0) begin
          fails++;
          $display("FAIL %s_an: an=%h, need one low bit", nm, an);
        end else begin
          seen[idx] = 1'b1;
          if (seg !== ~e[idx]) begin
            fails++;
            $display("FAIL %s_dig%0d: seg=%h, need %h", nm, idx, seg, ~e[idx]);
          end
          if (pidx >= 0) begin
            tests++;
            if (idx != (pidx + 1) % 8) begin
              fails++;
              $display("FAIL %s_order: idx=%0d, need %0d", nm, idx, (pidx + 1) % 8);
            end
          end
          pidx = idx;
        end
      end
      @(negedge clk);
    end
    tests++;
    if (seen !== 8'hFF || dp !== 1'b1) begin
      fails++;
      $display("FAIL %s_cover: seen=%h dp=%b, need FF and 1", nm, seen, dp);
    end
  endtask

  task automatic test_reset;
    logic rose = 1'b0;
    disp_t e;
    reset = 1'b1;
    value = '0;
    @(negedge clk);
    tests++;
    if (seg !== 7'h7F || an !== 8'hFF || dp !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: seg=%h an=%h dp=%b busy=%b, need 7f ff 1 0",
               seg, an, dp, busy);
    end
    reset = 1'b0;
    exp_q.push_back(model(32'd0));
    repeat (3) @(negedge clk);
    tests++;
    if (an !== 8'hFF) begin
      fails++;
      $display("FAIL first_an_early: an=%h, need ff", an);
    end
    @(negedge clk);
    tests++;
    if (an !== 8'hFE || seg !== 7'h40) begin
      fails++;
      $display("FAIL first_an: an=%h seg=%h, need fe 40", an, seg);
    end
    repeat (36) begin
      if (busy !== 1'b0) rose = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (rose) begin
      fails++;
      $display("FAIL idle_busy: busy rose=1, need 0");
    end
    pop(e);
    check_scan(e, "zero");
  endtask

  task automatic test_value(input logic [31:0] v, input string nm);
    int hi;
    disp_t e;
    drive(v);
    wait_done(hi);
    tests++;
    if (hi != 33) begin
      fails++;
      $display("FAIL %s_busy_len: %0d cycles, need 33", nm, hi);
    end
    pop(e);
    check_scan(e, nm);
  endtask

  task automatic test_back_to_back;
    int c = 0, pulses = 1, falls = 0, fall_at = -1;
    logic pb;
    logic [7:0] pa;
    logic got7 = 1'b0;
    logic [6:0] s7 = 'x;
    disp_t e;
    drive(32'd7);
    while (busy !== 1'b1 && c < 20) begin
      @(negedge clk); c++;
    end
    repeat (10) @(negedge clk);
    drive(32'd42);
    pb = busy;
    pa = an;
    for (int k = 0; k < 200 && falls < 2; k++) begin
      @(negedge clk);
      if (busy === 1'b0 && pb === 1'b1) begin
        falls++;
        if (falls == 1) fall_at = k;
      end
      if (busy === 1'b1 && pb === 1'b0) pulses++;
      if (falls == 1 && k > fall_at && !got7 && an === 8'hFE && pa !== 8'hFE) begin
        got7 = 1'b1;
        s7 = seg;
      end
      pb = busy;
      pa = an;
    end
    tests++;
    if (pulses != 2 || falls != 2) begin
      fails++;
      $display("FAIL b2b_pulses: rises=%0d falls=%0d, need 2 2", pulses, falls);
    end
    pop(e);
    tests++;
    if (!got7 || s7 !== ~e[0]) begin
      fails++;
      $display("FAIL b2b_first: seg=%h seen=%b, need %h", s7, got7, ~e[0]);
    end
    pop(e);
    check_scan(e, "b2b_42");
  endtask

  task automatic test_reset_mid;
    int c = 0, hi;
    disp_t e;
    drive(32'd999);
    while (busy !== 1'b1 && c < 20) begin
      @(negedge clk); c++;
    end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: busy=%b an=%h seg=%h dp=%b, need 0 ff 7f 1",
               busy, an, seg, dp);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_done(hi);
    tests++;
    if (hi != 33) begin
      fails++;
      $display("FAIL mid_busy_len: %0d cycles, need 33", hi);
    end
    pop(e);
    check_scan(e, "mid_999");
  endtask

  initial begin
    test_reset;
    test_value(32'd12345, "v12345");
    test_value(32'hFFFF_FFFF, "err");
    test_value(32'd100000000, "ovf");
    test_value(32'd99999999, "nines");
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
